eae_unit: RTL and testbench
===========================

EAE_UNIT -- requirements
Module: eae_unit

Interface
REQ-001 Parameter: WIDTH, default 12, word width of every data port; the only supported value is 12.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  operation select, sampled with start: 0 = MUL, 1 = DVI.
REQ-006 ac_in  input  WIDTH  current AC; high word of the DVI dividend, addend for MUL.
REQ-007 mq_in  input  WIDTH  current MQ; multiplier for MUL, low word of the DVI dividend.
REQ-008 operand  input  WIDTH  memory operand (MB); multiplicand for MUL, divisor for DVI.
REQ-009 busy  output  1  high while an operation is in progress, including the DONE cycle.
REQ-010 done  output  1  one-cycle pulse when results are valid.
REQ-011 ac_mul  output  WIDTH  high word of the MUL result.
REQ-012 mq_mul  output  WIDTH  low word of the MUL result.
REQ-013 ac_dvi  output  WIDTH  DVI remainder.
REQ-014 mq_dvi  output  WIDTH  DVI quotient.
REQ-015 link_dvi  output  1  DVI overflow / divide-by-zero flag.

Function
REQ-016 The block SHALL implement the FSM states IDLE, MUL, DIV and DONE; after reset it SHALL be in IDLE.
REQ-017 In IDLE, start=1 SHALL capture ac_in, mq_in, operand and op into internal registers; later input changes SHALL NOT affect the operation.
REQ-018 The state after IDLE with start=1 SHALL be: MUL if op=0; DIV if op=1 and there is no overflow; DONE if op=1 with overflow.
REQ-019 MUL and DIV SHALL each run exactly 12 iterations, one result bit per cycle, counted by a 4-bit counter 0..11; after iteration 11 the FSM SHALL move to DONE.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 Latency (start sampled at edge k): the MUL and normal DVI paths SHALL have busy=1 for cycles k+1..k+13 and done=1 in cycle k+13; the DVI overflow path SHALL have busy=1 and done=1 in cycle k+1 only.
REQ-022 A start in any non-IDLE state SHALL be ignored and SHALL NOT be queued; start together with done SHALL also be ignored.
REQ-023 MUL arithmetic SHALL be {ac_mul,mq_mul} = mq_in*operand + ac_in as an unsigned 24-bit value; this sum cannot overflow, so no flag is produced.
REQ-024 The MUL implementation SHALL be a shift-add, with one conditional add of operand and one shift per iteration.
REQ-025 DVI overflow SHALL be declared when ac_in >= operand (this includes operand=0).
REQ-026 When DVI does not overflow: mq_dvi SHALL be floor({ac_in,mq_in}/operand), ac_dvi SHALL be the remainder, and link_dvi SHALL be 0.
REQ-027 The DVI implementation SHALL be restoring or non-restoring division, one quotient bit per iteration, with a 13-bit partial remainder.
REQ-028 When DVI overflows: link_dvi=1, ac_dvi=ac_in (captured value), mq_dvi=mq_in (captured value).
REQ-029 Result outputs SHALL update only on the transition into DONE and SHALL hold until the next completed operation of the same type.
REQ-030 MUL SHALL leave the DVI outputs unchanged, and vice versa.
REQ-031 No intermediate value SHALL be visible on any result output.
REQ-032 link_dvi SHALL update only on DVI completion.

Reset
REQ-033 reset=1 at a clock edge SHALL force: IDLE state, counter=0, busy=0, done=0, all result outputs=0, link_dvi=0.
REQ-034 reset SHALL take priority over start.
REQ-035 A reset asserted in the middle of an operation SHALL abort it with no done pulse, and the results of the aborted operation SHALL NOT be written.
REQ-036 The first start accepted after reset deasserts SHALL behave exactly like a start from power-up.

Verification
REQ-037 MUL, ac_in=0005, mq_in=0012, operand=0003 (octal) -> done at k+13, ac_mul=0000, mq_mul=0043, DVI outputs unchanged.
REQ-038 MUL, ac_in=mq_in=operand=7777 -> ac_mul=7777, mq_mul=0000 (4095*4095+4095 = 0xFFF000).
REQ-039 DVI, ac_in=0000, mq_in=0144, operand=0007 -> done at k+13, mq_dvi=0016, ac_dvi=0002, link_dvi=0.
REQ-040 DVI overflow/div-by-zero cases: ac_in=0005, mq_in=1234, operand=0005 -> done at k+1, link_dvi=1, ac_dvi=0005, mq_dvi=1234; and ac_in=0, operand=0 -> link_dvi=1.
REQ-041 Start pulses issued at k+3 and on the done cycle -> both ignored; exactly one done pulse is produced per accepted start.
REQ-042 reset asserted at k+6 of a MUL -> busy=0 and all outputs 0 at k+7, no done pulse; a new MUL issued afterwards completes correctly.

Source files
------------

// File: rtl/eae_unit.sv
// Extended arithmetic element: 12-bit unsigned multiply (shift-add) and
// 24/12 divide (restoring, one quotient bit per cycle), PDP-8 EAE style.
// Results are registered and published only on entry to DONE.
module eae_unit #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_mul,
    output logic [WIDTH-1:0] mq_mul,
    output logic [WIDTH-1:0] ac_dvi,
    output logic [WIDTH-1:0] mq_dvi,
    output logic             link_dvi
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Iteration counter runs 0..WIDTH-1; the last value triggers DONE.
    localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // MUL running high word / DIV remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // MUL multiplier shifting out / DIV quotient shifting in
    logic [WIDTH-1:0] mb_q, mb_d;       // captured operand
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] ac_mul_q, ac_mul_d;
    logic [WIDTH-1:0] mq_mul_q, mq_mul_d;
    logic [WIDTH-1:0] ac_dvi_q, ac_dvi_d;
    logic [WIDTH-1:0] mq_dvi_q, mq_dvi_d;
    logic             link_q, link_d;

    // Datapath terms shared by the next-state logic.
    logic [WIDTH:0]   mul_sum;          // conditional add with carry out
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0] mul_mq_next;
    logic [WIDTH:0]   div_trial;        // 13-bit partial remainder after shift-in
    logic             div_fits;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_mq_next;
    logic             dvi_ovf;

    // Per-iteration arithmetic for both operations, plus the DVI overflow test.
    always_comb begin
        mul_sum      = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
        mul_acc_next = mul_sum[WIDTH:1];
        mul_mq_next  = {mul_sum[0], mq_q[WIDTH-1:1]};

        div_trial    = {acc_q, mq_q[WIDTH-1]};
        div_fits     = (div_trial >= {1'b0, mb_q});
        // The remainder is always below the divisor, so it fits back in WIDTH bits.
        div_rem_next = div_fits ? WIDTH'(div_trial - {1'b0, mb_q}) : div_trial[WIDTH-1:0];
        div_mq_next  = {mq_q[WIDTH-2:0], div_fits};

        // Quotient would not fit in WIDTH bits (covers divide by zero).
        dvi_ovf      = (ac_in >= operand);
    end

    // Next-state, datapath and result-register logic.
    always_comb begin
        // NOTE: every signal starts from its held value so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        mb_d     = mb_q;
        ac_mul_d = ac_mul_q;
        mq_mul_d = mq_mul_q;
        ac_dvi_d = ac_dvi_q;
        mq_dvi_d = mq_dvi_q;
        link_d   = link_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = ac_in;
                    mq_d  = mq_in;
                    mb_d  = operand;
                    cnt_d = '0;
                    if (!op) begin
                        state_d = S_MUL;
                    end else if (dvi_ovf) begin
                        // Overflow finishes immediately and returns the operands.
                        state_d  = S_DONE;
                        ac_dvi_d = ac_in;
                        mq_dvi_d = mq_in;
                        link_d   = 1'b1;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end

            S_MUL: begin
                acc_d = mul_acc_next;
                mq_d  = mul_mq_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    ac_mul_d = mul_acc_next;
                    mq_mul_d = mul_mq_next;
                end
            end

            S_DIV: begin
                acc_d = div_rem_next;
                mq_d  = div_mq_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    ac_dvi_d = div_rem_next;
                    mq_dvi_d = div_mq_next;
                    link_d   = 1'b0;
                end
            end

            S_DONE: begin
                // A start arriving with done is deliberately dropped here.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the state being entered.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and result registers with synchronous reset that aborts any operation.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            mb_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ac_mul_q <= '0;
            mq_mul_q <= '0;
            ac_dvi_q <= '0;
            mq_dvi_q <= '0;
            link_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            mb_q     <= mb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ac_mul_q <= ac_mul_d;
            mq_mul_q <= mq_mul_d;
            ac_dvi_q <= ac_dvi_d;
            mq_dvi_q <= mq_dvi_d;
            link_q   <= link_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ac_mul   = ac_mul_q;
    assign mq_mul   = mq_mul_q;
    assign ac_dvi   = ac_dvi_q;
    assign mq_dvi   = mq_dvi_q;
    assign link_dvi = link_q;

endmodule

// File: tb/tb_eae_unit.sv
// Scoreboard bench for eae_unit: the driver pushes expected results computed
// with plain multiply/divide; the monitor pops on every done pulse and also
// checks busy and the held result outputs on every cycle.
module tb_eae_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [11:0] ac_in;
    logic [11:0] mq_in;
    logic [11:0] operand;
    logic        busy;
    logic        done;
    logic [11:0] ac_mul;
    logic [11:0] mq_mul;
    logic [11:0] ac_dvi;
    logic [11:0] mq_dvi;
    logic        link_dvi;

    eae_unit #(.WIDTH(12)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .ac_in    (ac_in),
        .mq_in    (mq_in),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .ac_mul   (ac_mul),
        .mq_mul   (mq_mul),
        .ac_dvi   (ac_dvi),
        .mq_dvi   (mq_dvi),
        .link_dvi (link_dvi)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] ac_mul;
        logic [11:0] mq_mul;
        logic [11:0] ac_dvi;
        logic [11:0] mq_dvi;
        logic        link;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          accepted    = 0;
    int          dones       = 0;

    // Reference model: last completed results of each operation type.
    logic [11:0] m_ac_mul = '0;
    logic [11:0] m_mq_mul = '0;
    logic [11:0] m_ac_dvi = '0;
    logic [11:0] m_mq_dvi = '0;
    logic        m_link   = 1'b0;

    // Monitor-side expectation of the visible result outputs.
    logic [48:0] vis = '0;
    logic        rst_now;
    exp_t        mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Behavioural model: plain 24-bit arithmetic on the operation's definition.
    task automatic model_op(input logic o, input logic [11:0] a, input logic [11:0] m,
                            input logic [11:0] b, output exp_t e);
        logic [23:0] p;
        logic [23:0] dvd;
        logic [23:0] q;
        logic [23:0] r;
        if (!o) begin
            p        = 24'(m) * 24'(b) + 24'(a);
            m_ac_mul = p[23:12];
            m_mq_mul = p[11:0];
        end else if (a >= b) begin
            m_link   = 1'b1;
            m_ac_dvi = a;
            m_mq_dvi = m;
        end else begin
            dvd      = {a, m};
            q        = dvd / 24'(b);
            r        = dvd % 24'(b);
            m_link   = 1'b0;
            m_mq_dvi = q[11:0];
            m_ac_dvi = r[11:0];
        end
        e.ac_mul  = m_ac_mul;
        e.mq_mul  = m_mq_mul;
        e.ac_dvi  = m_ac_dvi;
        e.mq_dvi  = m_mq_dvi;
        e.link    = m_link;
        e.exp_cyc = 0;
    endtask

    task automatic scramble_inputs();
        op      = 1'($urandom);
        ac_in   = 12'($urandom);
        mq_in   = 12'($urandom);
        operand = 12'($urandom);
    endtask

    // Wait (bounded) until the model says no operation is outstanding.
    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    endtask

    // Issue one accepted operation; returns with cyc equal to the accepting edge.
    task automatic issue(input logic o, input logic [11:0] a, input logic [11:0] m,
                         input logic [11:0] b);
        exp_t e;
        @(negedge clock);
        start   = 1'b1;
        op      = o;
        ac_in   = a;
        mq_in   = m;
        operand = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        scramble_inputs();
        model_op(o, a, m, b, e);
        e.exp_cyc = cyc + ((o && (a >= b)) ? 0 : 12);
        sb.push_back(e);
        accepted++;
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 40 && cyc != target; i++) @(negedge clock);
    endtask

    // Monitor: checks busy every cycle, pops the scoreboard on done, and
    // checks that result outputs only ever show completed values.
    initial begin
        forever begin
            @(posedge clock);
            rst_now = reset;
            @(negedge clock);
            if (rst_now) begin
                sb.delete();
                vis = '0;
                check("reset_busy", 64'(busy), 64'(0));
                check("reset_done", 64'(done), 64'(0));
            end else begin
                check("busy", 64'(busy), 64'(sb.size() != 0));
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 64'(done), 64'(0));
                    end else begin
                        mon_e = sb.pop_front();
                        dones++;
                        check("done_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
                        vis = {mon_e.ac_mul, mon_e.mq_mul, mon_e.ac_dvi, mon_e.mq_dvi, mon_e.link};
                    end
                end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
                    check("done_timeout", 64'(cyc), 64'(sb[0].exp_cyc));
                    mon_e = sb.pop_front();
                    vis = {mon_e.ac_mul, mon_e.mq_mul, mon_e.ac_dvi, mon_e.mq_dvi, mon_e.link};
                end
            end
            check("results", 64'({ac_mul, mq_mul, ac_dvi, mq_dvi, link_dvi}), 64'(vis));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int base;
        logic        o;
        logic [11:0] a;
        logic [11:0] m;
        logic [11:0] b;

        // Reset held with start asserted: reset must win.
        reset   = 1'b1;
        start   = 1'b1;
        op      = 1'b0;
        ac_in   = 12'o0005;
        mq_in   = 12'o0012;
        operand = 12'o0003;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);

        // Directed cases.
        issue(1'b0, 12'o0005, 12'o0012, 12'o0003);
        wait_idle();
        issue(1'b0, 12'o7777, 12'o7777, 12'o7777);
        wait_idle();
        issue(1'b1, 12'o0000, 12'o0144, 12'o0007);
        wait_idle();
        issue(1'b1, 12'o0005, 12'o1234, 12'o0005);
        wait_idle();
        issue(1'b1, 12'o0000, 12'o4321, 12'o0000);
        wait_idle();
        issue(1'b1, 12'o7776, 12'o7777, 12'o7777);
        wait_idle();

        // Starts at k+3 and in the done cycle are both ignored.
        issue(1'b0, 12'o0123, 12'o4567, 12'o0321);
        base = cyc;
        wait_cyc(base + 2);
        start = 1'b1;
        scramble_inputs();
        @(posedge clock);
        #1 start = 1'b0;
        wait_cyc(base + 12);
        start = 1'b1;
        scramble_inputs();
        @(posedge clock);
        #1 start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clock);

        // Reset in the middle of a MUL aborts it without a done pulse.
        issue(1'b0, 12'o1111, 12'o2222, 12'o3333);
        base = cyc;
        wait_cyc(base + 5);
        reset = 1'b1;
        @(posedge clock);
        #1;
        m_ac_mul = '0;
        m_mq_mul = '0;
        m_ac_dvi = '0;
        m_mq_dvi = '0;
        m_link   = 1'b0;
        accepted--;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        issue(1'b0, 12'o0005, 12'o0012, 12'o0003);
        wait_idle();

        // Randomized mix of operations and operand ranges.
        for (int n = 0; n < 40; n++) begin
            o = 1'($urandom);
            a = 12'($urandom);
            m = 12'($urandom);
            b = 12'($urandom);
            case ($urandom_range(0, 7))
                0: b = 12'o0000;
                1: begin a = 12'o7777; b = 12'o7777; end
                2: begin a = 12'o7776; m = 12'o7777; b = 12'o7777; end
                default: begin
                    if (o && b != 0) a = 12'($urandom_range(0, int'(b) - 1));
                end
            endcase
            wait_idle();
            issue(o, a, m, b);
        end
        wait_idle();
        repeat (5) @(negedge clock);

        check("done_count", 64'(dones), 64'(accepted));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
